// File: rtl/pc_gen_if.sv
// Control/fetch bundle between the branch controller, pc_gen and instruction memory.
// With MISALIGN_TRAP_EN defined the bundle also carries the misalign trap pulse.
interface pc_gen_if;
  logic [1:0]  npc_mux_sel;
  logic [31:0] pc_offset;
  logic [31:0] reg_offset;
  logic        stall;
  logic        irq;
  logic        mret;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        int_ack;
  logic [31:0] mepc;
  logic        in_handler;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;

  modport master (
    output npc_mux_sel, pc_offset, reg_offset, stall, irq, mret, fetch_ready,
    input  pc, fetch_valid, flush, int_ack, mepc, in_handler, misalign
  );

  modport slave (
    input  npc_mux_sel, pc_offset, reg_offset, stall, irq, mret, fetch_ready,
    output pc, fetch_valid, flush, int_ack, mepc, in_handler, misalign
  );
`else
  modport master (
    output npc_mux_sel, pc_offset, reg_offset, stall, irq, mret, fetch_ready,
    input  pc, fetch_valid, flush, int_ack, mepc, in_handler
  );

  modport slave (
    input  npc_mux_sel, pc_offset, reg_offset, stall, irq, mret, fetch_ready,
    output pc, fetch_valid, flush, int_ack, mepc, in_handler
  );
`endif
endinterface

// File: rtl/pc_gen.sv
// Fetch PC register: sequential advance, branch/jump redirect, single-level interrupt and mret.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VEC instead of being masked.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_PLUS4      = 2'd0,
    SEL_PC_OFFSET  = 2'd1,
    SEL_REG_OFFSET = 2'd2,
    SEL_INTERRUPT  = 2'd3
  } sel_e;

  state_e      state_q, state_d;
  sel_e        sel;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mepc_q, mepc_d;
  logic        mie_q, mie_d;
  logic        flush_q, flush_d;
  logic        int_ack_q, int_ack_d;
  logic        ret_q, ret_d;
  logic [31:0] plus4;
  logic [31:0] raw_tgt;
  logic [31:0] tgt;
  logic [31:0] seq_pc;
  logic [31:0] save_pc;
  logic        redirect;
  logic        fetch_done;
  logic        irq_take;
`ifdef MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
  logic        mis_trap;
`endif

  always_comb begin
    sel        = sel_e'(bus.npc_mux_sel);
    plus4      = pc_q + 32'd4;
    redirect   = (sel == SEL_PC_OFFSET) || (sel == SEL_REG_OFFSET);
    raw_tgt    = (sel == SEL_REG_OFFSET) ? (bus.reg_offset & 32'hFFFF_FFFE) : bus.pc_offset;
`ifdef MISALIGN_TRAP_EN
    tgt        = raw_tgt & 32'hFFFF_FFFD;
    mis_trap   = redirect && raw_tgt[1] && (state_q == RUN);
`else
    tgt        = raw_tgt & 32'hFFFF_FFFC;
`endif
    fetch_done = (state_q != BOOT) && bus.fetch_ready && !bus.stall;

    if (redirect)        seq_pc = tgt;
    else if (fetch_done) seq_pc = plus4;
    else                 seq_pc = pc_q;

    // Entry right after mret saves the return address itself: its instruction never executed.
    save_pc  = (ret_q && !redirect) ? pc_q : seq_pc;
    irq_take = (state_q == RUN) && mie_q && (bus.irq || (sel == SEL_INTERRUPT));

    state_d   = state_q;
    pc_d      = seq_pc;
    mepc_d    = mepc_q;
    mie_d     = mie_q;
    flush_d   = redirect;
    int_ack_d = 1'b0;
    ret_d     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_d     = 1'b0;
`endif

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
`ifdef MISALIGN_TRAP_EN
        if (mis_trap) begin
          pc_d      = TRAP_VEC;
          mepc_d    = raw_tgt;
          flush_d   = 1'b1;
          int_ack_d = 1'b1;
          mis_d     = 1'b1;
          mie_d     = 1'b0;
          state_d   = HANDLER;
        end else
`endif
        if (irq_take) begin
          pc_d      = TRAP_VEC;
          mepc_d    = save_pc;
          flush_d   = 1'b1;
          int_ack_d = 1'b1;
          mie_d     = 1'b0;
          state_d   = HANDLER;
        end
      end
      HANDLER: begin
        if (bus.mret) begin
          pc_d    = mepc_q;
          flush_d = 1'b1;
          mie_d   = 1'b1;
          ret_d   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      mepc_q    <= '0;
      mie_q     <= 1'b1;
      flush_q   <= 1'b0;
      int_ack_q <= 1'b0;
      ret_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mepc_q    <= mepc_d;
      mie_q     <= mie_d;
      flush_q   <= flush_d;
      int_ack_q <= int_ack_d;
      ret_q     <= ret_d;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= mis_d;
`endif
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = (state_q != BOOT);
  assign bus.flush       = flush_q;
  assign bus.int_ack     = int_ack_q;
  assign bus.mepc        = mepc_q;
  assign bus.in_handler  = (state_q == HANDLER);
`ifdef MISALIGN_TRAP_EN
  assign bus.misalign    = mis_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed plan with literal expectations, then random
// stimulus compared every cycle against a behavioural model.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_gen_if bus();

  pc_gen #(.RESET_PC(32'h0000_0000), .TRAP_VEC(32'h0000_0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Behavioural model: architectural view (booting / in handler / interrupts enabled).
  logic [31:0] m_pc, m_mepc;
  bit m_boot, m_inh, m_mie, m_ret, m_flush, m_ack, m_mis;

  always @(posedge clk) begin : model
    logic [31:0] raw, tgt, nxt;
    bit redir, done, was_ret, want_mis;
    if (rst) begin
      m_pc = 32'h0; m_mepc = 32'h0; m_boot = 1; m_inh = 0; m_mie = 1;
      m_ret = 0; m_flush = 0; m_ack = 0; m_mis = 0;
    end else begin
      redir = (bus.npc_mux_sel == 2'b01) || (bus.npc_mux_sel == 2'b10);
      raw   = (bus.npc_mux_sel == 2'b10) ? {bus.reg_offset[31:1], 1'b0} : bus.pc_offset;
`ifdef MISALIGN_TRAP_EN
      tgt      = {raw[31:2], 1'b0, raw[0]};
      want_mis = redir && raw[1];
`else
      tgt      = {raw[31:2], 2'b00};
      want_mis = 0;
`endif
      done    = !m_boot && bus.fetch_ready && !bus.stall;
      nxt     = redir ? tgt : (done ? m_pc + 32'd4 : m_pc);
      was_ret = m_ret;
      m_flush = redir; m_ack = 0; m_mis = 0; m_ret = 0;
      if (m_boot) begin
        m_boot = 0;
        m_pc   = nxt;
      end else if (m_inh) begin
        if (bus.mret) begin
          m_pc = m_mepc; m_inh = 0; m_mie = 1; m_flush = 1; m_ret = 1;
        end else m_pc = nxt;
      end else if (want_mis) begin
        m_mepc = raw; m_pc = 32'h100; m_inh = 1; m_mie = 0;
        m_flush = 1; m_ack = 1; m_mis = 1;
      end else if (m_mie && (bus.irq || bus.npc_mux_sel == 2'b11)) begin
        m_mepc = (was_ret && !redir) ? m_pc : nxt;
        m_pc = 32'h100; m_inh = 1; m_mie = 0; m_flush = 1; m_ack = 1;
      end else m_pc = nxt;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", bus.pc, m_pc);
      chk("fetch_valid", bus.fetch_valid, !m_boot);
      chk("flush", bus.flush, m_flush);
      chk("int_ack", bus.int_ack, m_ack);
      chk("mepc", bus.mepc, m_mepc);
      chk("in_handler", bus.in_handler, m_inh);
`ifdef MISALIGN_TRAP_EN
      chk("misalign", bus.misalign, m_mis);
`endif
    end
  end

  task automatic drv(input logic [1:0] s, input logic [31:0] po, input logic [31:0] ro,
                     input logic st, input logic iq, input logic mr, input logic rdy);
    bus.npc_mux_sel = s; bus.pc_offset = po; bus.reg_offset = ro;
    bus.stall = st; bus.irq = iq; bus.mret = mr; bus.fetch_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] s;
    logic [31:0] po, ro;
    int r;
    drv(2'b00, 32'h0, 32'h0, 0, 0, 0, 1);
    rst = 1;
    tick(); tick();
    cmp_en = 1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_fv", bus.fetch_valid, 1'b0);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_inh", bus.in_handler, 1'b0);
    chk("rst_mepc", bus.mepc, 32'h0);
    rst = 0;
    tick(); chk("boot_pc0", bus.pc, 32'h0); chk("boot_fv", bus.fetch_valid, 1'b1);
    tick(); chk("seq_pc4", bus.pc, 32'h4);
    tick(); chk("seq_pc8", bus.pc, 32'h8);
    drv(2'b00, 32'h0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("bp_hold", bus.pc, 32'h8); chk("bp_fv", bus.fetch_valid, 1'b1);
    end
    drv(2'b00, 32'h0, 32'h0, 1, 0, 0, 1);
    tick(); tick(); chk("stall_hold", bus.pc, 32'h8);
    drv(2'b00, 32'h0, 32'h0, 0, 0, 0, 1);
    tick(); chk("seq_pcC", bus.pc, 32'hC);
    tick(); chk("seq_pc10", bus.pc, 32'h10);
    drv(2'b01, 32'h40, 32'h0, 0, 0, 0, 1);
    tick(); chk("br_pc", bus.pc, 32'h40); chk("br_flush", bus.flush, 1'b1);
    drv(2'b00, 32'h0, 32'h0, 0, 0, 0, 1);
    tick(); chk("br_flush_off", bus.flush, 1'b0);
    drv(2'b10, 32'h0, 32'h55, 0, 0, 0, 1);
    tick(); chk("jalr_pc", bus.pc, 32'h54);
    drv(2'b01, 32'h20, 32'h0, 0, 0, 0, 1);
    tick();
    drv(2'b00, 32'h0, 32'h0, 0, 1, 0, 1);
    tick();
    chk("irq_pc", bus.pc, 32'h100); chk("irq_mepc", bus.mepc, 32'h24);
    chk("irq_ack", bus.int_ack, 1'b1); chk("irq_flush", bus.flush, 1'b1);
    chk("irq_inh", bus.in_handler, 1'b1);
    tick(); chk("no_nest_pc", bus.pc, 32'h104); chk("no_nest_ack", bus.int_ack, 1'b0);
    drv(2'b00, 32'h0, 32'h0, 0, 0, 1, 1);
    tick(); chk("mret_pc", bus.pc, 32'h24); chk("mret_inh", bus.in_handler, 1'b0);
    drv(2'b01, 32'h80, 32'h0, 0, 1, 0, 1);
    tick(); chk("irq_br_mepc", bus.mepc, 32'h80);
    drv(2'b00, 32'h0, 32'h0, 0, 0, 1, 1);
    tick(); chk("mret_br_pc", bus.pc, 32'h80);
    drv(2'b01, 32'h30, 32'h0, 0, 0, 0, 1);
    tick();
    drv(2'b00, 32'h0, 32'h0, 1, 1, 0, 1);
    tick(); chk("irq_stall_mepc", bus.mepc, 32'h30);
    drv(2'b00, 32'h0, 32'h0, 0, 1, 1, 1);
    tick(); chk("mret_irq_pc", bus.pc, 32'h30); chk("mret_irq_inh", bus.in_handler, 1'b0);
    drv(2'b00, 32'h0, 32'h0, 0, 1, 0, 1);
    tick(); chk("reenter_mepc", bus.mepc, 32'h30); chk("reenter_inh", bus.in_handler, 1'b1);
    drv(2'b00, 32'h0, 32'h0, 0, 0, 1, 1);
    tick();
    drv(2'b01, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 1);
    tick(); chk("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    drv(2'b00, 32'h0, 32'h0, 0, 0, 0, 1);
    tick(); chk("wrap_pc", bus.pc, 32'h0);
`ifdef MISALIGN_TRAP_EN
    drv(2'b01, 32'h42, 32'h0, 0, 0, 0, 1);
    tick(); chk("mis_pc", bus.pc, 32'h100); chk("mis_mepc", bus.mepc, 32'h42);
    chk("mis_flag", bus.misalign, 1'b1);
    drv(2'b00, 32'h0, 32'h0, 0, 0, 1, 1);
    tick();
`endif
    drv(2'b00, 32'h0, 32'h0, 0, 1, 0, 1);
    tick(); chk("pre_rst_inh", bus.in_handler, 1'b1);
    rst = 1;
    tick(); chk("hrst_pc", bus.pc, 32'h0); chk("hrst_inh", bus.in_handler, 1'b0);
    chk("hrst_fv", bus.fetch_valid, 1'b0);
    rst = 0;

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(99);
      s = (r < 70) ? 2'b00 : (r < 80) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
      po = $urandom; ro = $urandom;
      if ($urandom_range(3) != 0) po[1:0] = 2'b00;
      if ($urandom_range(15) == 0) po = 32'hFFFF_FFF8;
      drv(s, po, ro, $urandom_range(3) == 0, $urandom_range(7) == 0,
          $urandom_range(3) == 0, $urandom_range(3) != 0);
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
